// File: rtl/debug_uart_tx_pkg.sv
// Shared constants and FSM encoding for the debug-port UART transmitter.
// One packet is SYNC, seven payload bytes and an 8-bit wrap-around checksum.
package debug_uart_tx_pkg;

  localparam logic [7:0] DBG_SYNC         = 8'hA5;
  localparam int         DBG_NBYTES       = 9;
  localparam int         DBG_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/debug_uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. A synchronous clear restarts the period from zero.
module debug_uart_tx_baud_gen
  import debug_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DBG_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || bit_tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Snapshots the seven debug ports on a trigger and sends them as one 8N1
// packet: SYNC, p1..p7, checksum. tx comes straight from a flop.
module debug_uart_tx
  import debug_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DBG_CLKS_PER_BIT,
  parameter logic [7:0] SYNC_BYTE    = DBG_SYNC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_BYTE = 4'(DBG_NBYTES - 1);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] byte_idx_q, byte_idx_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       load, baud_clear, bit_tick;
  logic [7:0] ports [7];
  logic [7:0] pkt_q [DBG_NBYTES];
  logic [7:0] port_sum, cur_byte;

  assign ports[0] = debug_port1;
  assign ports[1] = debug_port2;
  assign ports[2] = debug_port3;
  assign ports[3] = debug_port4;
  assign ports[4] = debug_port5;
  assign ports[5] = debug_port6;
  assign ports[6] = debug_port7;

  assign port_sum = debug_port1 + debug_port2 + debug_port3 + debug_port4
                  + debug_port5 + debug_port6 + debug_port7;
  assign cur_byte = pkt_q[byte_idx_q];

  // Every state change restarts the bit period so timing never drifts.
  assign baud_clear = (state_q == S_IDLE) || (state_d != state_q);

  debug_uart_tx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (baud_clear),
    .bit_tick_o(bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          load       = 1'b1;
          byte_idx_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (byte_idx_q < LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_START;
          end else begin
            // The edge ending the last stop bit is the first IDLE sample point,
            // so a held trigger restarts with no idle bit in between.
            done_d = 1'b1;
            if (trigger) begin
              load       = 1'b1;
              byte_idx_d = '0;
              state_d    = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DBG_NBYTES; i++) pkt_q[i] <= '0;
    end else if (load) begin
      pkt_q[0] <= SYNC_BYTE;
      for (int i = 0; i < 7; i++) pkt_q[i+1] <= ports[i];
      pkt_q[DBG_NBYTES-1] <= port_sum;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: a line decoder pops expected bytes from a queue
// filled by a packet-level reference model at trigger time.
module tb_debug_uart_tx;

  localparam int CPB    = 4;
  localparam int BIT_T  = 10 * CPB;
  localparam int FRAME  = 9 * 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] p [7];
  logic       tx, busy, done;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  time        start_t [$];

  int  busy_total = 0, done_total = 0, done_fall = 0;
  logic busy_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .debug_port1(p[0]),
    .debug_port2(p[1]),
    .debug_port3(p[2]),
    .debug_port4(p[3]),
    .debug_port5(p[4]),
    .debug_port6(p[5]),
    .debug_port7(p[6]),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic expect_packet();
    int sum = 0;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(p[i]);
      sum += int'(p[i]);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  // ---------------- activity counters ----------------
  always @(negedge clk) begin
    if (busy) busy_total++;
    if (done) done_total++;
    if (done && busy_prev && !busy) done_fall++;
    busy_prev = busy;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic decode_byte();
    logic [9:0] bits;
    logic       width_ok;
    bits     = '0;
    width_ok = 1'b1;
    start_t.push_back($time);
    for (int b = 0; b < 10; b++) begin
      for (int s = 0; s < CPB; s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        if (reset) return;
        if (s == 0) bits[b] = tx;
        else if (tx !== bits[b]) width_ok = 1'b0;
      end
    end
    check("bit_width", {31'd0, width_ok}, 32'd1);
    check("stop_bit", {31'd0, bits[9]}, 32'd1);
    if (exp_q.size() == 0) check("unexpected_byte", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
    else check("byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) decode_byte();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_random_ports();
    for (int i = 0; i < 7; i++) p[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_trigger(input bit expect_pkt, input bit zero_after);
    @(posedge clk); #1;
    trigger = 1'b1;
    if (expect_pkt) expect_packet();
    @(posedge clk); #1;
    trigger = 1'b0;
    if (zero_after) for (int i = 0; i < 7; i++) p[i] = 8'h00;
  endtask

  task automatic check_gaps(input string name);
    int bad = 0;
    for (int i = 1; i < start_t.size(); i++)
      if (start_t[i] - start_t[i-1] != time'(BIT_T * 10)) bad++;
    check(name, bad, 0);
  endtask

  task automatic single_packet(input string name, input bit zero_after);
    int b0, d0, f0;
    b0 = busy_total; d0 = done_total; f0 = done_fall;
    start_t.delete();
    pulse_trigger(1'b1, zero_after);
    repeat (FRAME + 40) @(posedge clk);
    check({name, "_busy_cycles"}, busy_total - b0, FRAME);
    check({name, "_done_count"}, done_total - d0, 1);
    check({name, "_done_at_fall"}, done_fall - f0, 1);
    check({name, "_byte_count"}, start_t.size(), 9);
    check_gaps({name, "_byte_gaps"});
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int   b0, d0, f0, bad, wait_cnt;
    for (int i = 0; i < 7; i++) p[i] = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    // ascending ports, checksum 1C
    for (int i = 0; i < 7; i++) p[i] = 8'(i + 1);
    single_packet("ascending", 1'b0);

    // all FF with wrap, ports cleared right after trigger
    for (int i = 0; i < 7; i++) p[i] = 8'hFF;
    single_packet("all_ff", 1'b1);

    // random payloads
    for (int k = 0; k < 3; k++) begin
      set_random_ports();
      single_packet("random", 1'b0);
    end

    // triggers during a frame are ignored
    set_random_ports();
    b0 = busy_total; d0 = done_total;
    pulse_trigger(1'b1, 1'b0);
    repeat (47) @(posedge clk);
    set_random_ports();
    pulse_trigger(1'b0, 1'b0);
    repeat (148) @(posedge clk);
    pulse_trigger(1'b0, 1'b0);
    repeat (FRAME - 200 + 40) @(posedge clk);
    check("ignored_busy_cycles", busy_total - b0, FRAME);
    check("ignored_done_count", done_total - d0, 1);
    check("ignored_queue_drained", exp_q.size(), 0);

    // trigger held through done: back-to-back packets
    set_random_ports();
    b0 = busy_total; d0 = done_total;
    start_t.delete();
    @(posedge clk); #1;
    trigger = 1'b1;
    expect_packet();
    repeat (10) @(posedge clk);
    #1;
    set_random_ports();
    expect_packet();
    wait_cnt = 0;
    while (done !== 1'b1 && wait_cnt < FRAME + 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("b2b_done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (FRAME + 40) @(posedge clk);
    check("b2b_busy_cycles", busy_total - b0, 2 * FRAME);
    check("b2b_done_count", done_total - d0, 2);
    check("b2b_byte_count", start_t.size(), 18);
    check_gaps("b2b_byte_gaps");
    check("b2b_queue_drained", exp_q.size(), 0);

    // reset in the data bits of p3 (all zero so tx is low there)
    set_random_ports();
    p[2] = 8'h00;
    d0 = done_total;
    pulse_trigger(1'b1, 1'b0);
    repeat (130) @(posedge clk);
    #2;
    check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    check("abort_no_done", done_total - d0, 0);
    check("abort_idle_tx", {31'd0, tx}, 32'd1);
    set_random_ports();
    single_packet("after_abort", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
